program_sequencer: RTL and testbench

- Upstream neighbour of the instruction decoder in the 8-bit nanoprocessor.
- Owns the program counter (PC) and drives the program-memory address `pm_addr`. The decoder's instruction register loads the memory word at `pm_addr` on every clock unless `count_flag` is high.
- Executes `jmp` and `jmp_nz` using the decoder's `ir_nibble`.
- Implements four NOP-coded control extensions, which the decoder flags: timed stall (C8), loop mark (CF), loop end (D8) and halt (DF).

---
 rtl/program_sequencer_pkg.sv | 29 ++
 rtl/program_sequencer_stall_timer.sv | 35 +++
 rtl/program_sequencer.sv | 152 +++++++++++++++
 tb/tb_program_sequencer.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/program_sequencer_pkg.sv
//==============================================================================
// Module   : program_sequencer_pkg
// Purpose  : Shared constants, state encoding and helpers for the sequencer.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package program_sequencer_pkg;

  localparam int c_pc_width = 8;

  localparam logic [7:0] c_op_stall     = 8'hC8;
  localparam logic [7:0] c_op_loop_mark = 8'hCF;
  localparam logic [7:0] c_op_loop_end  = 8'hD8;
  localparam logic [7:0] c_op_halt      = 8'hDF;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_HALT  = 2'd2
  } seq_state_t;

  function automatic logic [c_pc_width-1:0] inc_addr(input logic [c_pc_width-1:0] a);
    return a + 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/program_sequencer_stall_timer.sv
//==============================================================================
// Module   : stall_timer
// Purpose  : Loadable down-counter with a zero flag, used to time C8 stalls.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module stall_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign zero = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/program_sequencer.sv
//==============================================================================
// Module   : program_sequencer
// Purpose  : Program counter, jumps, timed stall, single-level loop and halt.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module program_sequencer
  import program_sequencer_pkg::*;
#(
  parameter int STALL_CYCLES = 3,
  parameter int LOOP_ITER    = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  jmp,
  input  logic                  jmp_nz,
  input  logic [3:0]            jmp_addr,
  input  logic                  dont_jmp,
  input  logic                  NOPC8,
  input  logic                  NOPCF,
  input  logic                  NOPD8,
  input  logic                  NOPDF,
  output logic [c_pc_width-1:0] pm_addr,
  output logic [c_pc_width-1:0] pc,
  output logic [c_pc_width-1:0] from_PS,
  output logic                  count_flag,
  output logic                  halted
);

  seq_state_t            r_state;
  seq_state_t            w_state_nxt;
  logic [c_pc_width-1:0] r_pc;
  logic [c_pc_width-1:0] r_loop_addr;
  logic [3:0]            r_loop_cnt;
  logic                  r_started;
  logic [c_pc_width-1:0] w_pm_addr;
  logic                  w_count_flag;
  logic                  w_jmp_take;
  logic                  w_loop_nz;
  logic                  w_loop_set;
  logic                  w_loop_dec;
  logic                  w_stall_load;
  logic                  w_stall_dec;
  logic                  w_stall_zero;

  stall_timer #(
    .WIDTH(4)
  ) u_stall_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (w_stall_load),
    .load_val (4'(STALL_CYCLES - 1)),
    .dec      (w_stall_dec),
    .zero     (w_stall_zero)
  );

  assign w_jmp_take = jmp | (jmp_nz & ~dont_jmp);
  assign w_loop_nz  = (r_loop_cnt != 4'd0);

  // Until the first edge after reset, ir holds no fetched word, so the
  // control flags are ignored and address 0 is presented for the first fetch.
  always_comb begin
    w_state_nxt  = r_state;
    w_count_flag = 1'b0;
    w_stall_load = 1'b0;
    w_stall_dec  = 1'b0;
    w_loop_set   = 1'b0;
    w_loop_dec   = 1'b0;
    if (r_started) begin
      case (r_state)
        ST_RUN: begin
          w_count_flag = NOPC8;
          if (NOPDF) begin
            w_state_nxt = ST_HALT;
          end else if (NOPC8) begin
            w_state_nxt  = ST_STALL;
            w_stall_load = 1'b1;
          end else if (NOPCF) begin
            w_loop_set = 1'b1;
          end else if (NOPD8 && w_loop_nz && !w_jmp_take) begin
            w_loop_dec = 1'b1;
          end
        end
        ST_STALL: begin
          if (!w_stall_zero) begin
            w_count_flag = 1'b1;
            w_stall_dec  = 1'b1;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_HALT: begin
          w_count_flag = 1'b1;
        end
        default: begin
          w_state_nxt = ST_RUN;
        end
      endcase
    end
  end

  always_comb begin
    w_pm_addr = inc_addr(r_pc);
    if (!r_started) begin
      w_pm_addr = '0;
    end else if (r_state == ST_HALT) begin
      w_pm_addr = r_pc;
    end else if (w_count_flag) begin
      w_pm_addr = r_pc;
    end else if (w_jmp_take) begin
      w_pm_addr = {r_pc[c_pc_width-1:4], jmp_addr};
    end else if (NOPD8 && w_loop_nz) begin
      w_pm_addr = r_loop_addr;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_started   <= 1'b0;
      r_pc        <= '0;
      r_loop_addr <= '0;
      r_loop_cnt  <= 4'd0;
    end else begin
      r_started <= 1'b1;
      r_pc      <= w_pm_addr;
      if (w_loop_set) begin
        r_loop_addr <= inc_addr(r_pc);
        r_loop_cnt  <= 4'(LOOP_ITER);
      end else if (w_loop_dec) begin
        r_loop_cnt <= r_loop_cnt - 4'd1;
      end
    end
  end

  assign pm_addr    = w_pm_addr;
  assign pc         = r_pc;
  assign from_PS    = r_pc;
  assign count_flag = w_count_flag;
  assign halted     = (r_state == ST_HALT);

endmodule

`default_nettype wire

// File: tb/tb_program_sequencer.sv
//==============================================================================
// Module   : tb_program_sequencer
// Purpose  : Scoreboard bench for program_sequencer with a small decoder model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_program_sequencer;

  logic       clk;
  logic       reset_n;
  logic       dont_jmp;
  logic [7:0] pm_addr;
  logic [7:0] pc;
  logic [7:0] from_PS;
  logic       count_flag;
  logic       halted;

  logic [7:0] mem [256];
  logic [7:0] ir;

  wire        jmp      = (ir[7:4] == 4'h8);
  wire        jmp_nz   = (ir[7:4] == 4'h9);
  wire [3:0]  jmp_addr = ir[3:0];
  wire        nop_c8   = (ir == 8'hC8);
  wire        nop_cf   = (ir == 8'hCF);
  wire        nop_d8   = (ir == 8'hD8);
  wire        nop_df   = (ir == 8'hDF);

  typedef struct {
    string      name;
    logic [7:0] pc;
    logic [7:0] pm;
    logic       cf;
    logic       h;
  } exp_t;

  exp_t q[$];
  int   vectors;
  int   miscompares;

  program_sequencer #(
    .STALL_CYCLES(3),
    .LOOP_ITER   (2)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .jmp       (jmp),
    .jmp_nz    (jmp_nz),
    .jmp_addr  (jmp_addr),
    .dont_jmp  (dont_jmp),
    .NOPC8     (nop_c8),
    .NOPCF     (nop_cf),
    .NOPD8     (nop_d8),
    .NOPDF     (nop_df),
    .pm_addr   (pm_addr),
    .pc        (pc),
    .from_PS   (from_PS),
    .count_flag(count_flag),
    .halted    (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decoder instruction register: loads the word at pm_addr unless held.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) ir <= 8'h00;
    else if (!count_flag) ir <= mem[pm_addr];
  end

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      vectors++;
      if (pc !== e.pc || from_PS !== e.pc || pm_addr !== e.pm ||
          count_flag !== e.cf || halted !== e.h) begin
        miscompares++;
        $display("FAIL %s: got pc=%h from_PS=%h pm_addr=%h count_flag=%b halted=%b, want pc=%h pm_addr=%h count_flag=%b halted=%b",
                 e.name, pc, from_PS, pm_addr, count_flag, halted, e.pc, e.pm, e.cf, e.h);
      end
    end
  end

  task automatic step(input string name, input logic [7:0] exp_pc, input logic [7:0] exp_pm,
                      input logic exp_cf, input logic exp_h);
    exp_t e;
    e.name = name; e.pc = exp_pc; e.pm = exp_pm; e.cf = exp_cf; e.h = exp_h;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset_n     = 1'b0;
    dont_jmp    = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h01] = 8'h10;
    mem[8'h05] = 8'hC8;
    mem[8'h07] = 8'h8F;
    mem[8'h08] = 8'hFF;
    mem[8'h10] = 8'hCF;
    mem[8'h12] = 8'hD8;
    mem[8'h14] = 8'h9A;
    mem[8'h15] = 8'h9A;
    mem[8'h1A] = 8'h8F;
    mem[8'h20] = 8'hDF;

    @(posedge clk); #1;
    step("reset", 8'h00, 8'h00, 1'b0, 1'b0);
    reset_n = 1'b1;
    step("boot", 8'h00, 8'h00, 1'b0, 1'b0);
    step("first_fetch", 8'h00, 8'h01, 1'b0, 1'b0);
    step("second_fetch", 8'h01, 8'h02, 1'b0, 1'b0);
    step("seq_02", 8'h02, 8'h03, 1'b0, 1'b0);
    step("seq_03", 8'h03, 8'h04, 1'b0, 1'b0);
    step("seq_04", 8'h04, 8'h05, 1'b0, 1'b0);
    step("stall_c1", 8'h05, 8'h05, 1'b1, 1'b0);
    step("stall_c2", 8'h05, 8'h05, 1'b1, 1'b0);
    step("stall_c3", 8'h05, 8'h05, 1'b1, 1'b0);
    step("stall_rel", 8'h05, 8'h06, 1'b0, 1'b0);
    step("post_stall", 8'h06, 8'h07, 1'b0, 1'b0);
    step("jmp_0f", 8'h07, 8'h0F, 1'b0, 1'b0);
    step("landed_0f", 8'h0F, 8'h10, 1'b0, 1'b0);
    step("loop_mark", 8'h10, 8'h11, 1'b0, 1'b0);
    step("body_1", 8'h11, 8'h12, 1'b0, 1'b0);
    step("loop_end_1", 8'h12, 8'h11, 1'b0, 1'b0);
    step("body_2", 8'h11, 8'h12, 1'b0, 1'b0);
    step("loop_end_2", 8'h12, 8'h11, 1'b0, 1'b0);
    step("body_3", 8'h11, 8'h12, 1'b0, 1'b0);
    step("loop_exit", 8'h12, 8'h13, 1'b0, 1'b0);
    step("after_loop", 8'h13, 8'h14, 1'b0, 1'b0);
    step("jmp_nz_blocked", 8'h14, 8'h15, 1'b0, 1'b0);
    dont_jmp = 1'b0;
    step("jmp_nz_taken", 8'h15, 8'h1A, 1'b0, 1'b0);
    dont_jmp = 1'b1;
    step("jmp_1f", 8'h1A, 8'h1F, 1'b0, 1'b0);
    step("seq_1f", 8'h1F, 8'h20, 1'b0, 1'b0);
    step("halt_fetch", 8'h20, 8'h21, 1'b0, 1'b0);
    for (int i = 0; i < 50; i++) step("halted", 8'h21, 8'h21, 1'b1, 1'b1);

    reset_n = 1'b0;
    step("async_reset", 8'h00, 8'h00, 1'b0, 1'b0);

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h35] = 8'h8A;
    step("reset2", 8'h00, 8'h00, 1'b0, 1'b0);
    reset_n = 1'b1;
    step("boot2", 8'h00, 8'h00, 1'b0, 1'b0);
    for (int k = 0; k < 'h35; k++) step("walk_lo", 8'(k), 8'(k + 1), 1'b0, 1'b0);
    step("jmp_3a", 8'h35, 8'h3A, 1'b0, 1'b0);
    for (int k = 'h3A; k < 'hFF; k++) step("walk_hi", 8'(k), 8'(k + 1), 1'b0, 1'b0);
    step("wrap", 8'hFF, 8'h00, 1'b0, 1'b0);
    step("after_wrap", 8'h00, 8'h01, 1'b0, 1'b0);

    @(negedge clk); #1;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
